// File: rtl/vigna_mem_responder.sv
// rtl/vigna_mem_responder.sv - valid/ready single-port RAM responder with byte strobes and wait states.
// Optional out-of-range fault detection is enabled by defining VIGNA_MEM_FAULT_EN.
module vigna_mem_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata
`ifdef VIGNA_MEM_FAULT_EN
  ,
  output logic        fault
`endif
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                 state;
  logic [3:0]             wait_cnt;
  logic [ADDR_BITS-1:0]   word;
  logic [31:0]            wdata;
  logic [3:0]             wstrb;
  logic                   in_range;
  logic                   access;
  logic [31:0]            mem [0:DEPTH-1];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{d_addr[1:0], d_addr[31:ADDR_BITS+2]};

  assign access = (state == BUSY) && (wait_cnt == 4'd0);

`ifdef VIGNA_MEM_FAULT_EN
  logic in_range_q;
  assign in_range = in_range_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_range_q <= 1'b1;
      fault      <= 1'b0;
    end else begin
      if (state == IDLE && d_valid)
        in_range_q <= ~|d_addr[31:ADDR_BITS+2];
      if (access && !in_range_q)
        fault <= 1'b1;
    end
  end
`else
  assign in_range = 1'b1;
`endif

  // Storage has no reset; a reset coinciding with the access edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && access && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i])
          mem[word][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      d_ready  <= 1'b0;
      d_rdata  <= 32'd0;
      word     <= '0;
      wdata    <= 32'd0;
      wstrb    <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          d_ready <= 1'b0;
          if (d_valid) begin
            word     <= d_addr[ADDR_BITS+1:2];
            wdata    <= d_wdata;
            wstrb    <= d_wstrb;
            wait_cnt <= WS;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            d_ready <= 1'b1;
            d_rdata <= (wstrb != 4'd0 || !in_range) ? 32'd0 : mem[word];
            state   <= RESP;
          end
        end
        RESP: begin
          // Turnaround cycle: a request present here waits for the next IDLE edge.
          d_ready <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          d_ready <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vigna_mem_responder.sv
// tb/tb_vigna_mem_responder.sv - scoreboard bench for vigna_mem_responder at 0, 2 and 3 wait states.
module tb_vigna_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  int          sel;

  logic        v0, v2, v3;
  logic        r0, r2, r3;
  logic [31:0] rd0, rd2, rd3;
`ifdef VIGNA_MEM_FAULT_EN
  logic        f0, f2, f3;
`endif

  assign v0 = valid && (sel == 0);
  assign v2 = valid && (sel == 2);
  assign v3 = valid && (sel == 3);

  vigna_mem_responder #(.ADDR_BITS(10), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .d_valid(v0), .d_ready(r0), .d_addr(addr),
    .d_wdata(wdata), .d_wstrb(wstrb), .d_rdata(rd0)
`ifdef VIGNA_MEM_FAULT_EN
    , .fault(f0)
`endif
  );

  vigna_mem_responder #(.ADDR_BITS(10), .WAIT_STATES(2)) u2 (
    .clk(clk), .rst(rst), .d_valid(v2), .d_ready(r2), .d_addr(addr),
    .d_wdata(wdata), .d_wstrb(wstrb), .d_rdata(rd2)
`ifdef VIGNA_MEM_FAULT_EN
    , .fault(f2)
`endif
  );

  vigna_mem_responder #(.ADDR_BITS(10), .WAIT_STATES(3)) u3 (
    .clk(clk), .rst(rst), .d_valid(v3), .d_ready(r3), .d_addr(addr),
    .d_wdata(wdata), .d_wstrb(wstrb), .d_rdata(rd3)
`ifdef VIGNA_MEM_FAULT_EN
    , .fault(f3)
`endif
  );

  logic        cur_ready;
  logic [31:0] cur_rdata;
  always_comb begin
    cur_ready = r0;
    cur_rdata = rd0;
    case (sel)
      2: begin cur_ready = r2; cur_rdata = rd2; end
      3: begin cur_ready = r3; cur_rdata = rd3; end
      default: begin cur_ready = r0; cur_rdata = rd0; end
    endcase
  end

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] exp_q [$];
  logic [31:0] model [int];

  // Pushes the expected response, drives one transfer, checks latency, data and pulse width.
  task automatic do_xfer(input int s, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] exp_v;
    logic [31:0] got;
    logic        oor;
    int          key;
    int          cycles;
    key = s * 4096 + int'(a[11:2]);
    oor = 1'b0;
`ifdef VIGNA_MEM_FAULT_EN
    oor = (a[31:12] != 20'd0);
`endif
    if (!model.exists(key)) model[key] = 32'd0;
    if (st != 4'd0) begin
      exp_v = 32'd0;
      if (!oor)
        for (int i = 0; i < 4; i++)
          if (st[i]) model[key][8*i +: 8] = wd[8*i +: 8];
    end else begin
      exp_v = oor ? 32'd0 : model[key];
    end
    exp_q.push_back(exp_v);
    @(negedge clk);
    sel = s; addr = a; wdata = wd; wstrb = st; valid = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!cur_ready && cycles < 40);
    checks++;
    if (cycles != s + 2) begin
      fails++;
      $display("FAIL latency ws=%0d addr=%h: got %0d edges, expected %0d", s, a, cycles, s + 2);
    end
    got = exp_q.pop_front();
    checks++;
    if (cur_rdata !== got) begin
      fails++;
      $display("FAIL rdata ws=%0d addr=%h: got %h, expected %h", s, a, cur_rdata, got);
    end
    valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cur_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_pulse ws=%0d: got %b, expected 0", s, cur_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; valid = 1'b0; sel = 0; addr = 32'd0; wdata = 32'd0; wstrb = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({r0, r2, r3} !== 3'b000) begin
      fails++;
      $display("FAIL reset_ready: got %b, expected 000", {r0, r2, r3});
    end
    checks++;
    if ({rd0, rd2, rd3} !== 96'd0) begin
      fails++;
      $display("FAIL reset_rdata: got %h %h %h, expected zeros", rd0, rd2, rd3);
    end
`ifdef VIGNA_MEM_FAULT_EN
    checks++;
    if ({f0, f2, f3} !== 3'b000) begin
      fails++;
      $display("FAIL reset_fault: got %b, expected 000", {f0, f2, f3});
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    do_xfer(0, 32'h10, 32'h0000002A, 4'b1111);
    do_xfer(0, 32'h10, 32'h0, 4'b0000);
  endtask

  task automatic test_strobe;
    do_xfer(0, 32'h20, 32'hFFFFFFFF, 4'b1111);
    do_xfer(0, 32'h20, 32'h00AB0000, 4'b0100);
    do_xfer(0, 32'h20, 32'h0, 4'b0000);
    do_xfer(0, 32'h23, 32'h00000011, 4'b0001);
    do_xfer(0, 32'h20, 32'h0, 4'b0000);
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [3];
    logic        prev;
    int          n;
    int          last;
    addrs[0] = 32'h100; addrs[1] = 32'h104; addrs[2] = 32'h1F8;
    do_xfer(3, addrs[0], 32'hCAFE0001, 4'b1111);
    do_xfer(3, addrs[1], 32'hCAFE0002, 4'b1111);
    do_xfer(3, addrs[2], 32'hCAFE0003, 4'b1111);
    for (int k = 0; k < 3; k++) exp_q.push_back(model[3 * 4096 + int'(addrs[k][11:2])]);
    @(negedge clk);
    sel = 3; addr = addrs[0]; wstrb = 4'd0; wdata = 32'd0; valid = 1'b1;
    n = 0; last = 0; prev = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (cur_ready) begin
        checks++;
        if (prev) begin
          fails++;
          $display("FAIL b2b_double_ready at cycle %0d: got 1, expected 0", c);
        end
        if (n > 0) begin
          checks++;
          if (c - last != 6) begin
            fails++;
            $display("FAIL b2b_interval: got %0d, expected 6", c - last);
          end
        end
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL b2b_extra_response: got rdata %h, expected none", cur_rdata);
        end else if (cur_rdata !== exp_q[0]) begin
          fails++;
          $display("FAIL b2b_rdata %0d: got %h, expected %h", n, cur_rdata, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        last = c;
        n++;
        if (n < 3) addr = addrs[n];
        else valid = 1'b0;
      end
      prev = cur_ready;
    end
    valid = 1'b0;
    checks++;
    if (n != 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d responses, expected 3", n);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    do_xfer(2, 32'h40, 32'hA5A5A5A5, 4'b1111);
    do_xfer(2, 32'h40, 32'h0, 4'b0000);
    @(negedge clk);
    sel = 2; addr = 32'h40; wdata = 32'h12345678; wstrb = 4'b1111; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (r2 !== 1'b0) begin
      fails++;
      $display("FAIL midreset_ready: got %b, expected 0", r2);
    end
    checks++;
    if (rd2 !== 32'd0) begin
      fails++;
      $display("FAIL midreset_rdata: got %h, expected 00000000", rd2);
    end
    @(negedge clk);
    rst = 1'b0;
    do_xfer(2, 32'h40, 32'h0, 4'b0000);
  endtask

  task automatic test_fault;
    do_xfer(0, 32'h0, 32'h11111111, 4'b1111);
`ifdef VIGNA_MEM_FAULT_EN
    checks++;
    if (f0 !== 1'b0) begin
      fails++;
      $display("FAIL fault_early: got %b, expected 0", f0);
    end
`endif
    do_xfer(0, 32'h00001000, 32'h00000055, 4'b1111);
`ifdef VIGNA_MEM_FAULT_EN
    checks++;
    if (f0 !== 1'b1) begin
      fails++;
      $display("FAIL fault_set: got %b, expected 1", f0);
    end
`endif
    do_xfer(0, 32'h0, 32'h0, 4'b0000);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_strobe;
    test_back_to_back;
    test_reset_mid;
    test_fault;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/vigna_mem_responder.md
# vigna_mem_responder

Synchronous single-port memory responder for the vigna core's valid/ready memory interface, i.e. the target side of the `d_*` bus (and of the `i_*` bus with `d_wstrb` tied to zero). It accepts one request at a time, applies per-byte write strobes, returns full-word read data, and inserts a programmable number of wait states. It replaces ad-hoc behavioural memories in simulation and serves as the on-chip RAM in small SoC builds.

## Interface
- `ADDR_BITS`, 10: log2 of memory depth in 32-bit words (depth = 2^ADDR_BITS).
- `WAIT_STATES`, 0: extra cycles between request acceptance and `d_ready`; legal range 0..15.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `d_valid` in 1: request present; initiator holds it and the request fields stable until it sees `d_ready`.
- `d_ready` out 1: one-cycle completion pulse.
- `d_addr` in 32: byte address; word index = `d_addr[ADDR_BITS+1:2]`; `d_addr[1:0]` ignored.
- `d_wdata` in 32: write data, already lane-aligned by the initiator.
- `d_wstrb` in 4: byte-lane write enables; 0 = read.
- `d_rdata` out 32: read data, valid in the `d_ready` cycle.
- `fault` out 1: sticky access-fault flag (present only with `VIGNA_MEM_FAULT_EN`).

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: at an edge with `d_valid`=1, capture `d_addr`/`d_wdata`/`d_wstrb` and load `wait_cnt` = `WAIT_STATES`; go to BUSY.
- BUSY: at an edge with `wait_cnt`≠0, decrement. At an edge with `wait_cnt`=0, perform the access on the captured values, set `d_ready`=1, go to RESP.
- Access: for each lane i with `wstrb[i]`=1, write `wdata[8i+7:8i]` to that byte of the word; unselected bytes keep their contents. Write (`wstrb`≠0): `d_rdata` = 0. Read: `d_rdata` = full stored word.
- RESP: at the next edge, `d_ready`=0 and the FSM goes to IDLE. A `d_valid` present at that edge is not accepted; it is sampled at the following IDLE edge. This gives a mandatory one-cycle turnaround.
- If `d_valid` drops during BUSY (protocol violation), the transfer still completes using the captured values.
- `d_rdata` holds its value until the next completion.
- Memory contents are not initialised by `rst`.

## Timing
- Reset values: `d_ready`=0, `d_rdata`=0, `fault`=0, FSM=IDLE, `wait_cnt`=0.
- `rst` mid-transfer: FSM goes to IDLE immediately. A pending write that has not reached its access edge is dropped. Memory is unaffected otherwise.
- Latency: with acceptance at edge E0, `d_ready` is high in the cycle after edge E0+1+`WAIT_STATES`.
- `WAIT_STATES`=0: `d_ready` is visible one cycle after the acceptance cycle.
- Throughput: one transfer per `WAIT_STATES`+3 cycles under continuously asserted `d_valid`.
- `d_ready` is never high for two consecutive cycles.

## Configuration
- `VIGNA_MEM_FAULT_EN` defined:
  - An address with any bit of `d_addr[31:ADDR_BITS+2]` set is out of range.
  - Out-of-range writes are suppressed and out-of-range reads return 0.
  - `fault` is set at the completion edge of the faulting transfer and stays set until `rst`.
  - Completion timing is unchanged.
- `VIGNA_MEM_FAULT_EN` not defined: the `fault` port is absent, upper address bits are ignored, and accesses wrap modulo depth.

## Test plan
- Reset, then write 0x0000002A with strobe 4'b1111 to 0x10, then read 0x10: `d_ready` one cycle after each acceptance cycle (`WAIT_STATES`=0), and the read returns 0x0000002A.
- Write 0xFFFFFFFF to 0x20, then write 0x00AB0000 with strobe 4'b0100, then read 0x20: returns 0xFFABFFFF.
- `WAIT_STATES`=3 with `d_valid` held high for three back-to-back reads: each `d_ready` pulse lasts one cycle, pulses are 6 cycles apart, and there is no double acceptance.
- Assert `rst` during BUSY of a write of 0x12345678 to 0x40 (`WAIT_STATES`=2), then read 0x40: the old value is returned, and `d_ready`/`d_rdata` were 0 in the cycle after reset.
- With `VIGNA_MEM_FAULT_EN` and `ADDR_BITS`=10, write 0x55 to 0x00001000: `fault`=1 after completion, and word 0 is unchanged.
- Repeat the out-of-range write with the macro undefined: a read of 0x0 returns 0x00000055.
